// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   NUM_CH independent runtime-programmable clock dividers driven from clk_i.
//   Each channel counts 0..Deff-1 (Deff = max(divisor, 1)) and raises a one-cycle
//   terminal-count strobe on the edge that wraps the counter. The output is either
//   a 50% square wave (mode 0) or a copy of the terminal strobe (mode 1).
//   New settings are written to a per-channel shadow and move to the active set
//   at the next terminal edge (or on the next edge while counting is disabled),
//   so a running output never sees a truncated or stretched period.
//
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset, overrides every other input
//   en_i       global count enable shared by all channels
//   load_i     per-channel strobe writing div_in_i / mode_in_i into the shadow
//   div_in_i   divisors, channel i at [i*CNT_W +: CNT_W]
//   mode_in_i  per-channel mode for the load, 0 = square, 1 = pulse
//   clk_out_o  divided output per channel, registered
//   tc_o       terminal-count strobe per channel, registered
//   pending_o  shadow holds settings that are not applied yet

module clock_divider_multi #(
  parameter int unsigned      CNT_W       = 32,
  parameter int unsigned      NUM_CH      = 2,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(50_000_000)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH*CNT_W-1:0] div_in_i,
  input  logic [NUM_CH-1:0]       mode_in_i,
  output logic [NUM_CH-1:0]       clk_out_o,
  output logic [NUM_CH-1:0]       tc_o,
  output logic [NUM_CH-1:0]       pending_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch

    // Active settings and counter
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    // Shadow settings written by load_i
    logic [CNT_W-1:0] sdiv_q, sdiv_d;
    logic             smode_q, smode_d;
    logic             pend_q, pend_d;
    // Registered outputs
    logic             out_q, out_d;
    logic             tc_q, tc_d;

    // Decode helpers
    logic [CNT_W-1:0] deff;
    logic             term;
    logic             apply;
    logic             mode_chg;
    logic             next_mode;

    always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      mode_d  = mode_q;
      sdiv_d  = sdiv_q;
      smode_d = smode_q;
      out_d   = out_q;
      tc_d    = 1'b0;

      // A zero divisor behaves as one, so the compare target never underflows.
      deff      = (div_q == '0) ? CNT_W'(1) : div_q;
      term      = en_i && (cnt_q == (deff - CNT_W'(1)));
      // Shadow moves to active at a period boundary, or immediately while halted.
      apply     = pend_q && (term || !en_i);
      mode_chg  = apply && (smode_q != mode_q);
      next_mode = apply ? smode_q : mode_q;

      if (en_i) begin
        if (term) begin
          cnt_d = '0;
          tc_d  = 1'b1;
          if (mode_chg) begin
            // Restart from low so a mode switch never produces a runt pulse.
            out_d = 1'b0;
          end else if (next_mode) begin
            out_d = 1'b1;
          end else begin
            out_d = ~out_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mode_q) begin
            out_d = 1'b0;
          end
        end
      end else if (apply) begin
        cnt_d = '0;
        if (mode_chg) begin
          out_d = 1'b0;
        end
      end

      if (apply) begin
        div_d  = sdiv_q;
        mode_d = smode_q;
      end

      // A load on the applying edge refills the shadow and keeps pending set.
      pend_d = (pend_q && !apply) || load_i[gi];
      if (load_i[gi]) begin
        sdiv_d  = div_in_i[gi*CNT_W +: CNT_W];
        smode_d = mode_in_i[gi];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q   <= '0;
        div_q   <= DEFAULT_DIV;
        mode_q  <= 1'b0;
        sdiv_q  <= DEFAULT_DIV;
        smode_q <= 1'b0;
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        tc_q    <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        mode_q  <= mode_d;
        sdiv_q  <= sdiv_d;
        smode_q <= smode_d;
        pend_q  <= pend_d;
        out_q   <= out_d;
        tc_q    <= tc_d;
      end
    end

    assign clk_out_o[gi] = out_q;
    assign tc_o[gi]      = tc_q;
    assign pending_o[gi] = pend_q;

  end : g_ch

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_CH = 2;
  localparam int          DEF    = 4;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       mode_in;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tc;
  logic [NUM_CH-1:0]       pending;

  int n_cmp = 0;
  int n_err = 0;

  clock_divider_multi #(
    .CNT_W      (CNT_W),
    .NUM_CH     (NUM_CH),
    .DEFAULT_DIV(CNT_W'(DEF))
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .load_i   (load),
    .div_in_i (div_in),
    .mode_in_i(mode_in),
    .clk_out_o(clk_out),
    .tc_o     (tc),
    .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks cycles left until the next terminal edge.
  int m_left  [NUM_CH];
  int m_div   [NUM_CH];
  int m_mode  [NUM_CH];
  int m_sdiv  [NUM_CH];
  int m_smode [NUM_CH];
  int m_pend  [NUM_CH];
  int m_out   [NUM_CH];
  int m_tc    [NUM_CH];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_left[c] = DEF; m_div[c] = DEF; m_mode[c] = 0; m_sdiv[c] = DEF;
        m_smode[c] = 0; m_pend[c] = 0; m_out[c] = 0; m_tc[c] = 0;
      end else begin
        bit is_term, do_apply, switched;
        int new_mode;
        is_term  = en && (m_left[c] == 1);
        do_apply = (m_pend[c] != 0) && (is_term || !en);
        switched = do_apply && (m_smode[c] != m_mode[c]);
        new_mode = do_apply ? m_smode[c] : m_mode[c];
        m_tc[c]  = is_term ? 1 : 0;
        if (en) begin
          if (is_term) begin
            m_left[c] = do_apply ? eff(m_sdiv[c]) : eff(m_div[c]);
            if (switched)      m_out[c] = 0;
            else if (new_mode) m_out[c] = 1;
            else               m_out[c] = 1 - m_out[c];
          end else begin
            m_left[c]--;
            if (m_mode[c] == 1) m_out[c] = 0;
          end
        end else if (do_apply) begin
          m_left[c] = eff(m_sdiv[c]);
          if (switched) m_out[c] = 0;
        end
        if (do_apply) begin
          m_div[c]  = m_sdiv[c];
          m_mode[c] = m_smode[c];
          m_pend[c] = 0;
        end
        if (load[c]) begin
          m_sdiv[c]  = int'(div_in[c*CNT_W +: CNT_W]);
          m_smode[c] = int'(mode_in[c]);
          m_pend[c]  = 1;
        end
      end
    end
  endtask

  // One clock: DUT samples inputs at the edge, model follows, outputs compared after.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      check_eq($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_out[c]));
      check_eq($sformatf("tc[%0d]", c), 32'(tc[c]), 32'(m_tc[c]));
      check_eq($sformatf("pending[%0d]", c), 32'(pending[c]), 32'(m_pend[c]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_load(input int c, input int d, input bit m);
    load[c] = 1'b1;
    div_in[c*CNT_W +: CNT_W] = CNT_W'(d);
    mode_in[c] = m;
  endtask

  initial begin
    int cnt_tc, cnt_hi, guard;
    rst = 1'b1; en = 1'b0; load = '0; div_in = '0; mode_in = '0;

    // Reset state
    do_reset();
    check_eq("reset_clk_out", 32'(clk_out), 32'd0);
    check_eq("reset_tc", 32'(tc), 32'd0);
    check_eq("reset_pending", 32'(pending), 32'd0);

    // Default divisor 4, square: 16 cycles hold 4 tc and 8 high cycles
    en = 1'b1;
    cnt_tc = 0; cnt_hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt_tc += int'(tc[1]);
      cnt_hi += int'(clk_out[1]);
    end
    check_eq("default_tc_count", 32'(cnt_tc), 32'd4);
    check_eq("default_high_count", 32'(cnt_hi), 32'd8);

    // Switch ch0 to pulse mode, div 3; ch1 keeps running
    set_load(0, 3, 1'b1);
    tick();
    load = '0;
    for (int i = 0; i < 14; i++) tick();

    // Divisors 0 and 1 in square, 1 in pulse
    set_load(0, 1, 1'b1);
    set_load(1, 0, 1'b0);
    tick();
    load = '0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("pulse_div1_clk_out", 32'(clk_out[0]), 32'd1);
    check_eq("pulse_div1_tc", 32'(tc[0]), 32'd1);
    set_load(1, 1, 1'b0);
    tick();
    load = '0;
    for (int i = 0; i < 6; i++) tick();

    // Freeze at count 2 of D=4 for 5 cycles, terminal 2 cycles after resuming
    do_reset();
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b1;
    tick();
    check_eq("resume_first_tc", 32'(tc[1]), 32'd0);
    tick();
    check_eq("resume_second_tc", 32'(tc[1]), 32'd1);

    // Load on the exact terminal edge while the shadow holds div 2
    do_reset();
    en = 1'b1;
    set_load(0, 2, 1'b0);
    tick();
    load = '0;
    guard = 0;
    while (m_left[0] != 1 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("term_align_bound", 32'(guard < 20), 32'd1);
    set_load(0, 6, 1'b0);
    tick();
    load = '0;
    check_eq("term_load_pending", 32'(pending[0]), 32'd1);
    tick();
    tick();
    check_eq("second_apply_pending", 32'(pending[0]), 32'd0);
    check_eq("second_apply_tc", 32'(tc[0]), 32'd1);
    for (int i = 0; i < 14; i++) tick();

    // Reset with a pending shadow discards it
    set_load(1, 7, 1'b1);
    tick();
    load = '0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_tc", 32'(tc), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(199) == 0);
      en   = ($urandom_range(9) != 0);
      load = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(19) == 0) set_load(c, int'($urandom_range(9)), 1'($urandom_range(1)));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
